// File: rtl/ucsbece154b_fifo_pkg.sv
// rtl/ucsbece154b_fifo_pkg.sv - width helpers and parameter check for the FWFT FIFO

// Elaboration-time guard on depth and almost-full threshold.
`define UCSBECE154B_FIFO_CHECK_PARAMS(NR, AF) \
  if (((NR) < 2) || ((AF) < 1) || ((AF) > (NR))) begin : g_param_err \
    $error("ucsbece154b_fifo: NR_ENTRIES must be >= 2 and AF_THRESH in 1..NR_ENTRIES"); \
  end

package ucsbece154b_fifo_pkg;

  // Pointer width: enough bits to index n slots, never less than one.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Count width: must represent 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ucsbece154b_fifo_ptr.sv
// rtl/ucsbece154b_fifo_ptr.sv - wrapping pointer register for any depth

module ucsbece154b_fifo_ptr
  import ucsbece154b_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [ptr_w(DEPTH)-1:0]   ptr_o
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] ptr_q, ptr_d;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register; clear (reset or flush) wins over increment.
  always_ff @(posedge clk_i) begin
    if (clr_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ucsbece154b_fifo_fwft.sv
// rtl/ucsbece154b_fifo_fwft.sv - parametrised FWFT FIFO; optional UCSBECE154B_FIFO_BYPASS_EN empty-queue bypass

module ucsbece154b_fifo_fwft
  import ucsbece154b_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NR_ENTRIES = 4,
  parameter int AF_THRESH  = NR_ENTRIES - 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          push_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic                          pop_i,
  output logic                          valid_o,
  output logic                          full_o,
  output logic                          almost_full_o,
  output logic [cnt_w(NR_ENTRIES)-1:0]  count_o
);

  localparam int PW = ptr_w(NR_ENTRIES);
  localparam int CW = cnt_w(NR_ENTRIES);

  `UCSBECE154B_FIFO_CHECK_PARAMS(NR_ENTRIES, AF_THRESH)

  logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         head_ptr, tail_ptr;
  logic                  clr, non_empty, full;
  logic                  valid, pop_acc, push_acc, pop_eff, push_eff;
  logic                  byp_consume;

  assign clr       = rst_i | flush_i;
  assign non_empty = (count_q != '0);
  assign full      = (count_q == CW'(NR_ENTRIES));

`ifdef UCSBECE154B_FIFO_BYPASS_EN
  logic byp_show;
  // An empty queue forwards the incoming word so it can be consumed this cycle.
  assign byp_show    = ~non_empty & push_i & ~clr;
  assign valid       = non_empty | byp_show;
  assign byp_consume = byp_show & pop_i;
  assign data_o      = byp_show ? data_i : (non_empty ? mem_q[head_ptr] : '0);
`else
  assign valid       = non_empty;
  assign byp_consume = 1'b0;
  assign data_o      = non_empty ? mem_q[head_ptr] : '0;
`endif

  assign pop_acc  = pop_i & valid;
  assign push_acc = push_i & (~full | pop_acc);

  // A bypass-consumed word never touches storage, pointers or count.
  assign pop_eff  = pop_acc  & ~byp_consume & ~clr;
  assign push_eff = push_acc & ~byp_consume & ~clr;

  assign valid_o       = valid;
  assign full_o        = full;
  assign almost_full_o = (count_q >= CW'(AF_THRESH));
  assign count_o       = count_q;

  ucsbece154b_fifo_ptr #(.DEPTH(NR_ENTRIES)) u_head (
    .clk_i (clk_i),
    .clr_i (clr),
    .inc_i (pop_eff),
    .ptr_o (head_ptr)
  );

  ucsbece154b_fifo_ptr #(.DEPTH(NR_ENTRIES)) u_tail (
    .clk_i (clk_i),
    .clr_i (clr),
    .inc_i (push_eff),
    .ptr_o (tail_ptr)
  );

  // Occupancy next-state: flush clears, push/pop move by one, both together hold.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_eff & ~pop_eff) begin
      count_d = count_q + 1'b1;
    end else if (pop_eff & ~push_eff) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Storage write at the tail; contents are not cleared by reset or flush.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[tail_ptr] <= data_i;
  end

endmodule

// File: tb/tb_ucsbece154b_fifo_fwft.sv
// tb/tb_ucsbece154b_fifo_fwft.sv - self-checking bench for the FWFT FIFO

module tb_ucsbece154b_fifo_fwft;

  localparam int DW = 8;
  localparam int N  = 5;
  localparam int AF = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          valid_o, full_o, almost_full_o;
  logic [2:0]    count_o;

  always #5 clk = ~clk;

  ucsbece154b_fifo_fwft #(.DATA_WIDTH(DW), .NR_ENTRIES(N), .AF_THRESH(AF)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .data_i        (data_i),
    .push_i        (push_i),
    .data_o        (data_o),
    .pop_i         (pop_i),
    .valid_o       (valid_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .count_o       (count_o)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    int            cnt;
    logic          full;
    logic          af;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic p, input logic q,
                     input logic [DW-1:0] d, input int c, input logic fu, input logic a);
    vec_t v;
    v.rst = r; v.flush = f; v.push = p; v.pop = q; v.din = d;
    v.cnt = c; v.full = fu; v.af = a;
    vecs.push_back(v);
  endtask

  task automatic run(input vec_t v, input int idx);
    logic popa, pusha;
    @(negedge clk);
    rst_i = v.rst; flush_i = v.flush; push_i = v.push; pop_i = v.pop; data_i = v.din;
    #1;
    if (v.pop && !v.rst && !v.flush && sb.size() > 0)
      chk($sformatf("pop_head[%0d]", idx), 32'(data_o), 32'(sb[0]));
    @(posedge clk);
    if (v.rst || v.flush) begin
      sb.delete();
    end else begin
      popa  = v.pop && (sb.size() > 0);
      pusha = v.push && ((sb.size() < N) || popa);
      if (popa)  void'(sb.pop_front());
      if (pusha) sb.push_back(v.din);
    end
    #1;
    chk($sformatf("count[%0d]", idx), 32'(count_o), 32'(v.cnt));
    chk($sformatf("full[%0d]", idx), 32'(full_o), 32'(v.full));
    chk($sformatf("afull[%0d]", idx), 32'(almost_full_o), 32'(v.af));
    chk($sformatf("valid[%0d]", idx), 32'(valid_o), 32'(sb.size() != 0));
    chk($sformatf("head[%0d]", idx), 32'(data_o), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
  endtask

  initial begin
    // reset state
    add(1, 0, 0, 0, 8'h00, 0, 0, 0);
    // fill 0x11..0x55
    for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 8'(17 * i), i, i == 5, i >= 4);
    // push while full is dropped
    add(0, 0, 1, 0, 8'h66, 5, 1, 1);
    // drain in order, then one extra pop on empty
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 1, 8'h00, 5 - i, 0, (5 - i) >= 4);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    // steady state at one entry, pointers wrap
    add(0, 0, 1, 0, 8'h00, 1, 0, 0);
    for (int k = 1; k <= 11; k++) add(0, 0, 1, 1, 8'(k), 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    // full with simultaneous push+pop
    for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 8'(8'hA0 + i), i, i == 5, i >= 4);
    add(0, 0, 1, 1, 8'hAA, 5, 1, 1);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 1, 8'h00, 5 - i, 0, (5 - i) >= 4);
    // flush with a concurrent push
    for (int i = 1; i <= 3; i++) add(0, 0, 1, 0, 8'(i), i, 0, 0);
    add(0, 1, 1, 0, 8'hBB, 0, 0, 0);
    add(0, 0, 1, 0, 8'h44, 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0);
    // reset mid-stream with push+pop
    add(0, 0, 1, 0, 8'h05, 1, 0, 0);
    add(0, 0, 1, 0, 8'h06, 2, 0, 0);
    add(1, 0, 1, 1, 8'h77, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // empty queue, push 0xCC with a same-cycle pop
    @(negedge clk);
    rst_i = 0; flush_i = 0; push_i = 1; pop_i = 1; data_i = 8'hCC;
    #1;
`ifdef UCSBECE154B_FIFO_BYPASS_EN
    chk("byp_valid_same", 32'(valid_o), 32'h1);
    chk("byp_data_same", 32'(data_o), 32'hCC);
`else
    chk("nobyp_valid_same", 32'(valid_o), 32'h0);
`endif
    @(posedge clk);
    #1;
`ifdef UCSBECE154B_FIFO_BYPASS_EN
    chk("byp_count_next", 32'(count_o), 32'h0);
    chk("byp_valid_next", 32'(valid_o), 32'h0);
`else
    chk("nobyp_count_next", 32'(count_o), 32'h1);
    chk("nobyp_data_next", 32'(data_o), 32'hCC);
    chk("nobyp_valid_next", 32'(valid_o), 32'h1);
    sb.push_back(8'hCC);
`endif
    begin
      vec_t v;
      v.rst = 0; v.flush = 0; v.push = 0; v.pop = 1; v.din = 8'h00;
      v.cnt = 0; v.full = 0; v.af = 0;
      run(v, 1000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fifo_fwft.md
Name: ucsbece154b_fifo_fwft

Overview:
- Parametrised first-word-fall-through (FWFT) FIFO, successor to the team's 4-entry registered-output queue.
- Supports any depth of 2 or more, not only powers of two.
- Head data is visible combinationally; exposes occupancy count and almost-full; synchronous flush for pipeline squash.
- Sits between fetch and decode as the instruction/branch-prediction queue; reusable for any DATA_WIDTH payload.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- NR_ENTRIES, 4, queue depth (>=2, any integer).
- AF_THRESH, NR_ENTRIES-1, almost_full_o asserts when count >= AF_THRESH (1..NR_ENTRIES).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of queue contents.
- data_i  in  DATA_WIDTH  push payload.
- push_i  in  1  push request.
- data_o  out  DATA_WIDTH  head entry (FWFT); 0 when valid_o=0.
- pop_i  in  1  pop request; consumes the head this cycle.
- valid_o  out  1  head entry valid (queue non-empty).
- full_o  out  1  count == NR_ENTRIES.
- almost_full_o  out  1  count >= AF_THRESH.
- count_o  out  $clog2(NR_ENTRIES+1)  current occupancy.

Behaviour:
- Reset is synchronous and active-high on rst_i, sampled on the rising edge of clk_i; single clock domain.
- Reset/flush: head=0, tail=0, count=0. Next cycle: valid_o=0, full_o=0, almost_full_o=0, count_o=0, data_o=0. Storage array is not cleared.
- rst_i has priority over flush_i; flush_i has priority over push/pop in the same cycle. Push data in a flush cycle is discarded.
- pop_acc = pop_i & valid_o. Pop while empty is ignored; no state change.
- push_acc = push_i & (~full_o | pop_acc). Push while full is accepted only with a simultaneous pop; otherwise it is dropped silently and no state changes.
- Pointers are PTR_W = max(1,$clog2(NR_ENTRIES)) bits. Increment wraps NR_ENTRIES-1 -> 0 explicitly; no reliance on power-of-two overflow.
- Count update:
  - push_acc only: +1.
  - pop_acc only: -1.
  - both: unchanged, and both pointers advance.
  - Count never exceeds NR_ENTRIES and never goes below 0.
- valid_o, full_o, almost_full_o and count_o are all derived from the count register, so they are consistent in the same cycle.
- Latency:
  - A push in cycle N is visible at data_o/valid_o in cycle N+1.
  - A pop in cycle N presents the next entry at data_o in cycle N+1.
  - data_o = mem[head] combinationally.
- Simultaneous push+pop with count==1: the head advances to the new entry; valid_o stays 1.
- Simultaneous push+pop with count==NR_ENTRIES: full_o stays 1; the new entry is written at the slot being vacated (tail==head).
- Reset mid-stream: in-flight push and pop are dropped; no partial update.

Optional Feature:
- Macro: UCSBECE154B_FIFO_BYPASS_EN.
- With the macro defined:
  - When count==0 and push_i=1 (no flush/reset), valid_o=1 and data_o=data_i combinationally in the same cycle.
  - If pop_i=1 that cycle, the entry is consumed directly: no write, pointers and count unchanged.
  - If pop_i=0, the entry is stored normally.
- Without the macro: no bypass; an empty queue shows valid_o=0 regardless of push_i, and the same-cycle pop is ignored.

Decomposition:
- Package ucsbece154b_fifo_pkg holds:
  - function ptr_w(n) returning max(1,$clog2(n));
  - function cnt_w(n) returning $clog2(n+1);
  - a parameter-check macro that errors at elaboration if NR_ENTRIES<2 or AF_THRESH is out of range.
- One sub-module, ucsbece154b_fifo_ptr: a wrapping pointer register parametrised by depth, with inputs inc_i and clr_i (reset|flush). Instantiated twice, for head and tail.

Test Plan:
- NR_ENTRIES=5, AF_THRESH=4. Push 0x11..0x55 on 5 consecutive cycles.
  - count_o goes 1..5; almost_full_o rises when count reaches 4; full_o=1 after the fifth push.
  - Then push 0x66 alone: dropped, count_o stays 5.
- From the full state, pop 5 times: data_o reads 0x11,0x22,0x33,0x44,0x55 in order; valid_o=0 after the last pop. A sixth pop changes nothing.
- Wrap test: push/pop for 12 cycles at 1 entry steady state with data 0..11. data_o equals the pushed value one cycle later; count_o stays 1; both pointers wrap past index 4.
- From full (5 entries), assert push 0xAA and pop together.
  - Head value is popped; full_o stays 1.
  - After 5 further pops, 0xAA is the last entry out.
- With 3 entries queued, assert flush_i together with push 0xBB: next cycle count_o=0, valid_o=0, data_o=0; 0xBB never appears.
- With 2 entries, assert rst_i with push+pop: all outputs at reset values next cycle.
- Bypass build: empty queue, push 0xCC with pop in the same cycle. data_o=0xCC and valid_o=1 that cycle; count_o stays 0 afterwards.
- Non-bypass build, same stimulus: valid_o=0 that cycle; count_o=1 and data_o=0xCC next cycle.
